// File: rtl/relm_uart_pkg.sv
// relm_uart_pkg: shared state encoding and line levels for the relm UART transmitter
package relm_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam logic IDLE_LVL = 1'b1;
  localparam logic START_LVL = 1'b0;
endpackage

// File: rtl/relm_uart_tx_shift.sv
// relm_uart_tx_shift: frame FSM, baud counter, shift register and registered txd
// Build with RELM_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module relm_uart_tx_shift
  import relm_uart_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       active,
  output logic       txd
);
  localparam int CW = $clog2(DIV);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] shift, shift_n;
  logic [2:0] idx, idx_n;
  logic tick, txd_n;
`ifdef RELM_UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par;
  always_ff @(posedge clk)
    if (rst) par <= 1'b0;
    else if (ready && load) par <= ^data;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  assign tick = cnt == CW'(DIV - 1);
  assign ready = state == IDLE || (state == STOP && tick);
  assign active = state != IDLE;
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n = idx;
    if (ready && load) begin
      state_n = START;
      shift_n = data;
    end else if (tick) begin
      case (state)
        START: begin
          state_n = DATA;
          idx_n = '0;
        end
        DATA: begin
          shift_n = shift >> 1;
          idx_n = idx + 3'd1;
          state_n = idx == 3'(DATA_BITS - 1) ? AFTER_DATA : DATA;
        end
        PARITY: state_n = STOP;
        STOP: state_n = IDLE;
        default: state_n = state;
      endcase
    end
    cnt_n = (state_n != state || state == IDLE || tick) ? '0 : cnt + CW'(1);
    // txd follows the current state one edge later, so each level lasts exactly DIV cycles
    txd_n = state == START ? START_LVL :
            state == DATA ? shift[0] :
`ifdef RELM_UART_TX_PARITY_EN
            state == PARITY ? par :
`endif
            IDLE_LVL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shift <= '0;
      idx <= '0;
      txd <= IDLE_LVL;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shift <= shift_n;
      idx <= idx_n;
      txd <= txd_n;
    end
  end
endmodule

// File: rtl/relm_uart_tx_io.sv
// relm_uart_tx_io: relm PUSH-channel consumer buffering bytes and sending them as 8N1 frames
// Optional even parity bit when RELM_UART_TX_PARITY_EN is defined.
module relm_uart_tx_io
  import relm_uart_pkg::*;
#(
  parameter int WD  = 32,
  parameter int WAD = 4,
  parameter int DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [WD:0] push_d,
  output logic        push_retry,
  output logic        txd_out,
  output logic        busy_out
);
  logic [7:0] mem [2**WAD];
  logic [WAD:0] wr_ptr, rd_ptr;
  logic full, empty, we, pop, ready, active;
  logic unused_hi;
  assign unused_hi = ^push_d[WD-1:8];
  assign full = wr_ptr[WAD-1:0] == rd_ptr[WAD-1:0] && wr_ptr[WAD] != rd_ptr[WAD];
  assign empty = wr_ptr == rd_ptr;
  // retry comes only from the pointer registers so the core can sample it without its strobe
  assign push_retry = full;
  assign we = push_d[WD] && !full;
  assign pop = ready && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      busy_out <= 1'b0;
    end else begin
      if (we) begin
        mem[wr_ptr[WAD-1:0]] <= push_d[7:0];
        wr_ptr <= wr_ptr + (WAD+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (WAD+1)'(1);
      busy_out <= active || !empty;
    end
  end
  relm_uart_tx_shift #(.DIV(DIV)) u_shift (
    .clk(clk),
    .rst(rst),
    .load(!empty),
    .data(mem[rd_ptr[WAD-1:0]]),
    .ready(ready),
    .active(active),
    .txd(txd_out)
  );
endmodule
